// File: rtl/rv32i_pkg.sv
// Shared RV32I constants, ALU operation set and the ALU itself.
// Imported by the core and the instruction memory.
package rv32i_pkg;
    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    // Bit 30 selects SUB only for register-register ops; for shifts it selects SRA in both forms.
    function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        case (f3)
            F3_ADD:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu(input alu_op_e op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'b0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_instr_mem.sv
// Instruction ROM, preloaded by the environment; combinational word read.
module rv32i_instr_mem
    import rv32i_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int IAW        = $clog2(IMEM_WORDS)
) (
    input  logic [IAW-1:0]  i_idx,
    output logic [XLEN-1:0] o_instr
);
    logic [XLEN-1:0] ROM [0:IMEM_WORDS-1];

    assign o_instr = ROM[i_idx];
endmodule

// File: rtl/rv32i_single_cycle.sv
// Single-cycle RV32I core: fetch, decode, execute and commit all in one clock.
// Register file, data RAM and PC update on the rising edge when RST is high.
module rv32i_single_cycle
    import rv32i_pkg::*;
#(
    parameter int              IMEM_WORDS = 256,
    parameter int              DMEM_WORDS = 256,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input logic CLK,
    input logic RST
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] regs [0:31];
    logic [XLEN-1:0] RAM  [0:DMEM_WORDS-1];

    logic [XLEN-1:0] w_instr, w_pc4, w_rs1_v, w_rs2_v, w_alu_b, w_alu_y, w_rd_data, w_next_pc;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_ram_rdata;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_f3;
    logic            w_alt, w_rd_we, w_ram_we, w_taken;
    alu_op_e         w_alu_op;
    logic [DAW-1:0]  w_ram_idx;

    rv32i_instr_mem #(.IMEM_WORDS(IMEM_WORDS)) DUT2 (
        .i_idx   (pc[IAW+1:2]),
        .o_instr (w_instr)
    );

    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_f3     = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];
    assign w_alt    = w_instr[30];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    assign w_rs1_v     = (w_rs1 == 5'd0) ? '0 : regs[w_rs1];
    assign w_rs2_v     = (w_rs2 == 5'd0) ? '0 : regs[w_rs2];
    assign w_pc4       = pc + 32'd4;
    assign w_alu_y     = alu(w_alu_op, w_rs1_v, w_alu_b);
    assign w_ram_idx   = w_alu_y[DAW+1:2];
    assign w_ram_rdata = RAM[w_ram_idx];

    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            F3_BEQ:  w_taken = (w_rs1_v == w_rs2_v);
            F3_BNE:  w_taken = (w_rs1_v != w_rs2_v);
            F3_BLT:  w_taken = ($signed(w_rs1_v) <  $signed(w_rs2_v));
            F3_BGE:  w_taken = ($signed(w_rs1_v) >= $signed(w_rs2_v));
            F3_BLTU: w_taken = (w_rs1_v <  w_rs2_v);
            F3_BGEU: w_taken = (w_rs1_v >= w_rs2_v);
            default: w_taken = 1'b0;
        endcase
    end

    // Unrecognised encodings fall through the defaults: no writes, PC advances by 4.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_b   = w_imm_i;
        w_rd_we   = 1'b0;
        w_rd_data = w_alu_y;
        w_ram_we  = 1'b0;
        w_next_pc = w_pc4;
        case (w_opcode)
            OPC_OP: begin
                w_alu_op = alu_decode(w_f3, w_alt, 1'b1);
                w_alu_b  = w_rs2_v;
                w_rd_we  = 1'b1;
            end
            OPC_OP_IMM: begin
                w_alu_op = alu_decode(w_f3, w_alt, 1'b0);
                w_rd_we  = 1'b1;
            end
            OPC_LUI: begin
                w_rd_data = w_imm_u;
                w_rd_we   = 1'b1;
            end
            OPC_AUIPC: begin
                w_rd_data = pc + w_imm_u;
                w_rd_we   = 1'b1;
            end
            OPC_JAL: begin
                w_rd_data = w_pc4;
                w_rd_we   = 1'b1;
                w_next_pc = pc + w_imm_j;
            end
            OPC_JALR: begin
                w_rd_data = w_pc4;
                w_rd_we   = 1'b1;
                w_next_pc = {w_alu_y[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: if (w_taken) w_next_pc = pc + w_imm_b;
            OPC_LOAD: if (w_f3 == F3_W) begin
                w_rd_data = w_ram_rdata;
                w_rd_we   = 1'b1;
            end
            OPC_STORE: if (w_f3 == F3_W) begin
                w_alu_b  = w_imm_s;
                w_ram_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= w_next_pc;
            if (w_rd_we && (w_rd != 5'd0)) regs[w_rd] <= w_rd_data;
        end
    end

    // Data RAM survives reset; only the store itself is suppressed while RST is low.
    always_ff @(posedge CLK) begin
        if (RST && w_ram_we) RAM[w_ram_idx] <= w_rs2_v;
    end
endmodule

// File: tb/tb_rv32i_single_cycle.sv
// Directed-program bench for rv32i_single_cycle; programs are poked into DUT2.ROM.
module tb_rv32i_single_cycle;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
    localparam logic [6:0] JALO = 7'h6f, JALRO = 7'h67, LUIO = 7'h37, AUIPCO = 7'h17;

    rv32i_single_cycle DUT (.CLK(CLK), .RST(RST));

    always #5 CLK = ~CLK;

    function automatic logic [31:0] enc_r(input logic [31:0] f7, rs2, rs1, f3, rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OP};
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, rs1, f3, rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], ST};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, rs2, rs1, f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], BR};
    endfunction
    function automatic logic [31:0] enc_u(input logic [31:0] imm20, rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], JALO};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) DUT.DUT2.ROM[i] = 32'h0;
    endtask

    task automatic hold_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic run(input int n);
        RST = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [31:0] first;
        for (int i = 0; i < 256; i++) DUT.DUT2.ROM[i] = $urandom;
        hold_reset();
        vectors++;
        if (DUT.pc !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_pc got %h want %h", DUT.pc, 32'h0);
        end
        for (int r = 0; r < 32; r++) begin
            vectors++;
            if (DUT.regs[r] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_reg x%0d got %h want %h", r, DUT.regs[r], 32'h0);
            end
        end
        first = enc_i(32'h55, 0, 0, 1, OPI);
        DUT.DUT2.ROM[0] = first;
        #1;
        vectors++;
        if (DUT.w_instr !== first) begin
            miscompares++;
            $display("FAIL reset_fetch got %h want %h", DUT.w_instr, first);
        end
        run(1);
        vectors++;
        if (DUT.regs[1] !== 32'h55 || DUT.pc !== 32'h4) begin
            miscompares++;
            $display("FAIL reset_first_exec x1 %h pc %h want x1 00000055 pc 00000004", DUT.regs[1], DUT.pc);
        end
    endtask

    task automatic test_alu();
        int          rn  [13] = '{1, 2, 3, 4, 5, 6, 7, 0, 8, 9, 12, 14, 15};
        logic [31:0] exp [13] = '{32'd5, 32'hFFFFFFFD, 32'd2, 32'd8, 32'd1, 32'd0, 32'hFFFFFFFE,
                                  32'd0, 32'hFFFFFFF8, 32'hA0, 32'hA, 32'hF, 32'd1};
        hold_reset();
        clear_rom();
        DUT.DUT2.ROM[0]  = enc_i(5, 0, 0, 1, OPI);
        DUT.DUT2.ROM[1]  = enc_i(-3, 0, 0, 2, OPI);
        DUT.DUT2.ROM[2]  = enc_r(0, 2, 1, 0, 3);
        DUT.DUT2.ROM[3]  = enc_r(7'h20, 2, 1, 0, 4);
        DUT.DUT2.ROM[4]  = enc_r(0, 1, 2, 2, 5);
        DUT.DUT2.ROM[5]  = enc_r(0, 1, 2, 3, 6);
        DUT.DUT2.ROM[6]  = enc_i(32'h401, 2, 5, 7, OPI);
        DUT.DUT2.ROM[7]  = enc_i(9, 0, 0, 0, OPI);
        DUT.DUT2.ROM[8]  = enc_r(0, 2, 1, 4, 8);
        DUT.DUT2.ROM[9]  = enc_r(0, 1, 1, 1, 9);
        DUT.DUT2.ROM[10] = enc_i(33, 0, 0, 13, OPI);
        DUT.DUT2.ROM[11] = enc_r(0, 13, 1, 1, 12);
        DUT.DUT2.ROM[12] = enc_i(28, 2, 5, 14, OPI);
        DUT.DUT2.ROM[13] = enc_i(-1, 1, 3, 15, OPI);
        run(14);
        for (int k = 0; k < 13; k++) begin
            vectors++;
            if (DUT.regs[rn[k]] !== exp[k]) begin
                miscompares++;
                $display("FAIL alu x%0d got %h want %h", rn[k], DUT.regs[rn[k]], exp[k]);
            end
        end
        vectors++;
        if (DUT.pc !== 32'd56) begin
            miscompares++;
            $display("FAIL alu_pc got %h want %h", DUT.pc, 32'd56);
        end
    endtask

    task automatic test_memory();
        hold_reset();
        clear_rom();
        DUT.DUT2.ROM[0] = enc_u(32'h12345, 1, LUIO);
        DUT.DUT2.ROM[1] = enc_i(32'h678, 1, 0, 1, OPI);
        DUT.DUT2.ROM[2] = enc_s(8, 1, 0, 2);
        DUT.DUT2.ROM[3] = enc_i(8, 0, 2, 2, LD);
        DUT.DUT2.ROM[4] = enc_i(-1, 0, 0, 3, OPI);
        DUT.DUT2.ROM[5] = enc_s(1030, 3, 0, 2);
        DUT.DUT2.ROM[6] = enc_i(4, 0, 2, 4, LD);
        run(7);
        vectors++;
        if (DUT.RAM[2] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL mem_sw RAM[2] got %h want %h", DUT.RAM[2], 32'h12345678);
        end
        vectors++;
        if (DUT.regs[2] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL mem_lw x2 got %h want %h", DUT.regs[2], 32'h12345678);
        end
        vectors++;
        if (DUT.RAM[1] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL mem_wrap RAM[1] got %h want %h", DUT.RAM[1], 32'hFFFFFFFF);
        end
        vectors++;
        if (DUT.regs[4] !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL mem_wrap_lw x4 got %h want %h", DUT.regs[4], 32'hFFFFFFFF);
        end
    endtask

    task automatic test_branch_loop();
        hold_reset();
        clear_rom();
        DUT.DUT2.ROM[0] = enc_i(0, 0, 0, 1, OPI);
        DUT.DUT2.ROM[1] = enc_i(10, 0, 0, 2, OPI);
        DUT.DUT2.ROM[2] = enc_i(1, 1, 0, 1, OPI);
        DUT.DUT2.ROM[3] = enc_i(1, 3, 0, 3, OPI);
        DUT.DUT2.ROM[4] = enc_b(-8, 2, 1, 1);
        DUT.DUT2.ROM[5] = enc_i(1, 0, 0, 4, OPI);
        run(33);
        vectors++;
        if (DUT.regs[1] !== 32'd10 || DUT.regs[3] !== 32'd10) begin
            miscompares++;
            $display("FAIL loop_count x1 %0d body %0d want 10 10", DUT.regs[1], DUT.regs[3]);
        end
        vectors++;
        if (DUT.regs[4] !== 32'd1 || DUT.pc !== 32'd24) begin
            miscompares++;
            $display("FAIL loop_exit x4 %0d pc %h want 1 00000018", DUT.regs[4], DUT.pc);
        end
    endtask

    task automatic test_branches();
        int          rn  [5] = '{10, 11, 12, 13, 14};
        logic [31:0] exp [5] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd1};
        hold_reset();
        clear_rom();
        DUT.DUT2.ROM[0]  = enc_i(-1, 0, 0, 1, OPI);
        DUT.DUT2.ROM[1]  = enc_i(1, 0, 0, 2, OPI);
        DUT.DUT2.ROM[2]  = enc_b(8, 2, 1, 4);
        DUT.DUT2.ROM[3]  = enc_i(1, 0, 0, 10, OPI);
        DUT.DUT2.ROM[4]  = enc_b(8, 2, 1, 6);
        DUT.DUT2.ROM[5]  = enc_i(1, 0, 0, 11, OPI);
        DUT.DUT2.ROM[6]  = enc_b(8, 1, 2, 5);
        DUT.DUT2.ROM[7]  = enc_i(1, 0, 0, 12, OPI);
        DUT.DUT2.ROM[8]  = enc_b(8, 2, 1, 7);
        DUT.DUT2.ROM[9]  = enc_i(1, 0, 0, 13, OPI);
        DUT.DUT2.ROM[10] = enc_b(8, 2, 1, 0);
        DUT.DUT2.ROM[11] = enc_i(1, 0, 0, 14, OPI);
        run(9);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (DUT.regs[rn[k]] !== exp[k]) begin
                miscompares++;
                $display("FAIL branch x%0d got %h want %h", rn[k], DUT.regs[rn[k]], exp[k]);
            end
        end
        vectors++;
        if (DUT.pc !== 32'd48) begin
            miscompares++;
            $display("FAIL branch_pc got %h want %h", DUT.pc, 32'd48);
        end
    endtask

    task automatic test_jumps();
        hold_reset();
        clear_rom();
        DUT.RAM[0] = 32'hDEADBEEF;
        DUT.RAM[1] = 32'hCAFEF00D;
        DUT.DUT2.ROM[0] = 32'h00000073;
        DUT.DUT2.ROM[1] = enc_i(0, 0, 0, 7, LD);
        DUT.DUT2.ROM[2] = enc_s(4, 0, 0, 0);
        DUT.DUT2.ROM[3] = 32'h0000000F;
        DUT.DUT2.ROM[4] = enc_j(8, 1);
        DUT.DUT2.ROM[5] = enc_j(12, 0);
        DUT.DUT2.ROM[6] = enc_i(0, 1, 0, 0, JALRO);
        DUT.DUT2.ROM[8] = enc_u(1, 5, AUIPCO);
        DUT.DUT2.ROM[9] = enc_i(3, 1, 0, 6, JALRO);
        run(5);
        vectors++;
        if (DUT.regs[1] !== 32'h14 || DUT.pc !== 32'h18) begin
            miscompares++;
            $display("FAIL jal x1 %h pc %h want 00000014 00000018", DUT.regs[1], DUT.pc);
        end
        vectors++;
        if (DUT.regs[7] !== 32'h0 || DUT.RAM[1] !== 32'hCAFEF00D) begin
            miscompares++;
            $display("FAIL illegal_nop x7 %h RAM[1] %h want 00000000 cafef00d", DUT.regs[7], DUT.RAM[1]);
        end
        run(1);
        vectors++;
        if (DUT.pc !== 32'h14) begin
            miscompares++;
            $display("FAIL jalr pc got %h want %h", DUT.pc, 32'h14);
        end
        run(2);
        vectors++;
        if (DUT.regs[5] !== 32'h1020 || DUT.pc !== 32'h24) begin
            miscompares++;
            $display("FAIL auipc x5 %h pc %h want 00001020 00000024", DUT.regs[5], DUT.pc);
        end
        run(1);
        vectors++;
        if (DUT.regs[6] !== 32'h28 || DUT.pc !== 32'h16) begin
            miscompares++;
            $display("FAIL jalr_lsb x6 %h pc %h want 00000028 00000016", DUT.regs[6], DUT.pc);
        end
        run(1);
        vectors++;
        if (DUT.pc !== 32'h22) begin
            miscompares++;
            $display("FAIL fetch_lowbits pc got %h want %h", DUT.pc, 32'h22);
        end
    endtask

    task automatic test_midrun_reset();
        hold_reset();
        clear_rom();
        DUT.RAM[3] = 32'h0;
        DUT.RAM[4] = 32'h0;
        DUT.DUT2.ROM[0] = enc_i(77, 0, 0, 3, OPI);
        DUT.DUT2.ROM[1] = enc_s(12, 3, 0, 2);
        DUT.DUT2.ROM[2] = enc_i(9, 0, 0, 4, OPI);
        DUT.DUT2.ROM[3] = enc_s(16, 4, 0, 2);
        run(3);
        vectors++;
        if (DUT.regs[3] !== 32'd77 || DUT.regs[4] !== 32'd9 || DUT.RAM[3] !== 32'd77) begin
            miscompares++;
            $display("FAIL midrun_pre x3 %0d x4 %0d RAM[3] %0d want 77 9 77", DUT.regs[3], DUT.regs[4], DUT.RAM[3]);
        end
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (DUT.pc !== 32'h0 || DUT.regs[3] !== 32'h0 || DUT.regs[4] !== 32'h0) begin
            miscompares++;
            $display("FAIL midrun_reset pc %h x3 %h x4 %h want all 0", DUT.pc, DUT.regs[3], DUT.regs[4]);
        end
        vectors++;
        if (DUT.RAM[3] !== 32'd77 || DUT.RAM[4] !== 32'd0) begin
            miscompares++;
            $display("FAIL midrun_ram RAM[3] %0d RAM[4] %0d want 77 0", DUT.RAM[3], DUT.RAM[4]);
        end
        run(1);
        vectors++;
        if (DUT.regs[3] !== 32'd77 || DUT.pc !== 32'h4) begin
            miscompares++;
            $display("FAIL midrun_restart x3 %0d pc %h want 77 00000004", DUT.regs[3], DUT.pc);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_branch_loop();
        test_branches();
        test_jumps();
        test_midrun_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rv32i_single_cycle.md
Name: rv32i_single_cycle

Overview:
- Self-contained single-cycle RV32I processor: PC, instruction ROM, decoder, 32x32 register file, ALU, branch unit and data RAM.
- Every instruction completes in one clock.
- The only ports are clock and reset. The program is preloaded hierarchically into the instruction ROM by the environment at time 0.
- Architectural state is inspected through the hierarchical names given below.

Parameters:
- IMEM_WORDS, 256, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 256, data RAM depth in 32-bit words.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-low.

Behaviour:
- Reset: at any rising CLK edge with RST=0:
  - PC <= RESET_PC.
  - All 32 registers <= 0.
  - Data RAM is not cleared.
  - ROM contents are never modified by reset.
- Hierarchy for verification:
  - Instruction memory is sub-module instance DUT2, holding array ROM[0:IMEM_WORDS-1] of 32-bit words, loadable by $readmemh.
  - Register file array is regs[0:31].
  - Data memory array is RAM[0:DMEM_WORDS-1].
  - Program counter register is pc.
- Fetch: combinational, instr = ROM[pc[log2(IMEM_WORDS)+1:2]]. pc[1:0] are ignored; the index wraps modulo depth.
- Execute and commit: combinational decode, ALU and address generation. On the rising edge with RST=1, in the same cycle:
  - rd write (if any),
  - RAM write (if any),
  - PC update.
- Register file:
  - 2 asynchronous read ports, 1 synchronous write port.
  - x0 reads 0 always; writes to x0 are discarded.
  - A read in the same cycle as a write returns the old value.
- Supported instructions:
  - LUI, AUIPC.
  - JAL, JALR: rd=pc+4; JALR target=(rs1+imm)&~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU: target=pc+imm.
  - LW, SW.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Arithmetic:
  - 32-bit wrap-around, no overflow flags.
  - Shifts use the low 5 bits of the shift amount.
  - SLT/BLT/BGE are signed; the U variants are unsigned.
- Immediates: I/S/B/U/J formats, sign-extended per RV32I.
- Memory:
  - LW/SW word address = (rs1+imm)[log2(DMEM_WORDS)+1:2]; low 2 bits ignored, index wraps.
  - LW read is combinational; SW write is synchronous.
- Next PC: pc+4 by default; branch target when the branch is taken; jump target for JAL/JALR.
- Any other opcode (including FENCE, ECALL, EBREAK, byte/half loads and stores, all-zero word): no register or memory write, PC=pc+4.
- Reset asserted mid-program: the instruction in that cycle is not committed; execution restarts at RESET_PC on the first edge with RST=1.

Decomposition:
- Shared package rv32i_pkg:
  - opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC);
  - funct3/funct7 constants;
  - ALU operation enum;
  - XLEN=32.
- Natural sub-module: rv32i_instr_mem, instantiated as DUT2 and containing ROM.
- ALU, register file and decoder may be inline or small sub-modules.

Test Plan:
- Reset: hold RST=0 for 2 edges with garbage ROM -> pc==0 and all regs==0. Release RST -> first fetch is from ROM[0].
- ALU: program addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2; sub x4,x1,x2; slt x5,x2,x1; sltu x6,x2,x1; srai x7,x2,1 -> x3=2, x4=8, x5=1, x6=0, x7=0xFFFFFFFE. Writes to x0 leave x0=0.
- Memory: lui x1,0x12345; addi x1,x1,0x678; sw x1,8(x0); lw x2,8(x0) -> RAM[2]=0x12345678, x2=0x12345678.
- Branch loop: x1 counts 0..10 via addi/bne loop -> x1=10 on exit, the loop body executes exactly 10 times, and the instruction after the loop executes.
- Jumps: jal x1,+8 at pc=0x10 -> x1=0x14, pc=0x18. jalr x0,0(x1) -> pc=0x14. auipc x5,1 at 0x20 -> x5=0x1020.
- Mid-run reset: deassert RST after a program writes x3, then assert RST for 1 edge -> pc=0, x3=0, RAM contents retained.
